// File: rtl/sensor_monitor_sched_if.sv
// rtl/sensor_monitor_sched_if.sv - sensor inputs and status/alarm outputs of the T/H monitor scheduler
interface sensor_monitor_sched_if;
    logic       enable;
    logic       t_raw;
    logic       h_raw;
    logic       ack;
    logic       sample_tick;
    logic       t_clean;
    logic       h_clean;
    logic       warning;
    logic       alarm;
    logic [1:0] level;
    logic [7:0] alarm_events;

    modport master (
        output enable, t_raw, h_raw, ack,
        input  sample_tick, t_clean, h_clean, warning, alarm, level, alarm_events
    );

    modport slave (
        input  enable, t_raw, h_raw, ack,
        output sample_tick, t_clean, h_clean, warning, alarm, level, alarm_events
    );
endinterface

// File: rtl/sensor_monitor_sched.sv
// rtl/sensor_monitor_sched.sv - prescaled T/H debounce and OFF/NORMAL/WARN/ALARM sequencer
// Optional ALARM entry counter enabled by SENSOR_MONITOR_EVENTS_EN.
module sensor_monitor_sched #(
    parameter int PRESCALE = 1000,
    parameter int DEBOUNCE = 3,
    parameter int HOLDOFF  = 8
) (
    input logic              clock,
    input logic              reset,
    sensor_monitor_sched_if.slave mon
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_NORMAL = 2'd1,
        S_WARN   = 2'd2,
        S_ALARM  = 2'd3
    } state_t;

    state_t          state;
    logic            alarm_q;
    logic [HW-1:0]   hold;
    logic [PW-1:0]   presc;
    logic            tick_q;
    logic [1:0]      raw;
    logic [1:0]      clean;
    logic [DW-1:0]   dcnt [2];

    logic any_set;
    logic both_set;
    logic exit_ok;
    logic to_off;
    logic clear_dbn;
    logic alarm_entry;

    assign raw      = {mon.h_raw, mon.t_raw};
    assign any_set  = |clean;
    assign both_set = &clean;
    assign exit_ok  = mon.ack && (hold == '0) && !both_set;

    // Clean lines must already read 0 in the first OFF cycle, so clear on the edge that enters OFF.
    assign to_off      = !mon.enable && ((state != S_ALARM) || exit_ok);
    assign clear_dbn   = (state == S_OFF) || to_off;
    assign alarm_entry = (state == S_WARN) && mon.enable && both_set;

    // tick_q is registered one count early so it is high exactly while presc == PRESCALE-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else if (!mon.enable) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            presc  <= (presc == PW'(PRESCALE - 1)) ? '0 : presc + 1'b1;
            tick_q <= (presc == PW'(PRESCALE - 2));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clean   <= 2'b00;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else if (clear_dbn) begin
            clean   <= 2'b00;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else if (tick_q) begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == clean[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE - 1)) begin
                    clean[i] <= raw[i];
                    dcnt[i]  <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_OFF;
            alarm_q <= 1'b0;
            hold    <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (mon.enable) state <= S_NORMAL;
                end
                S_NORMAL: begin
                    if (!mon.enable)  state <= S_OFF;
                    else if (any_set) state <= S_WARN;
                end
                S_WARN: begin
                    if (!mon.enable) begin
                        state <= S_OFF;
                    end else if (both_set) begin
                        state   <= S_ALARM;
                        alarm_q <= 1'b1;
                        hold    <= HW'(HOLDOFF);
                    end else if (!any_set) begin
                        state <= S_NORMAL;
                    end
                end
                S_ALARM: begin
                    // Enable is only looked at once the operator has released the alarm.
                    if (exit_ok) begin
                        alarm_q <= 1'b0;
                        if (!mon.enable)  state <= S_OFF;
                        else if (any_set) state <= S_WARN;
                        else              state <= S_NORMAL;
                    end else if (tick_q && (hold != '0)) begin
                        hold <= hold - 1'b1;
                    end
                end
                default: state <= S_OFF;
            endcase
        end
    end

`ifdef SENSOR_MONITOR_EVENTS_EN
    logic [7:0] events_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            events_q <= 8'd0;
        end else if (alarm_entry && (events_q != 8'hFF)) begin
            events_q <= events_q + 8'd1;
        end
    end

    assign mon.alarm_events = events_q;
`else
    logic unused_entry;
    assign unused_entry     = alarm_entry;
    assign mon.alarm_events = 8'd0;
`endif

    assign mon.sample_tick = tick_q;
    assign mon.t_clean     = clean[0];
    assign mon.h_clean     = clean[1];
    assign mon.warning     = any_set;
    assign mon.alarm       = alarm_q;
    assign mon.level       = state;

endmodule

// File: tb/tb_sensor_monitor_sched.sv
// tb/tb_sensor_monitor_sched.sv - directed table-driven bench for sensor_monitor_sched (PRESCALE=4, DEBOUNCE=3, HOLDOFF=2)
module tb_sensor_monitor_sched;

    logic clock;
    logic reset;

    sensor_monitor_sched_if mon ();

    sensor_monitor_sched #(
        .PRESCALE (4),
        .DEBOUNCE (3),
        .HOLDOFF  (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mon   (mon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       t;
        logic       h;
        logic       ack;
        int         n;
        logic [1:0] lvl;
        logic       alm;
        logic       tc;
        logic       hc;
        logic       wrn;
    } vec_t;

    vec_t tbl [17];
    int   n_pass;
    int   n_total;
    logic [7:0] exp_events;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Relative edge r counts from the enable restart that precedes row 0.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0,  8, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 12, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1,  4, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1,  4, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 11, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 13, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0,  3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 14, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1};

`ifdef SENSOR_MONITOR_EVENTS_EN
        exp_events = 8'd3;
`else
        exp_events = 8'd0;
`endif

        reset      = 1'b0;
        mon.enable = 1'b0;
        mon.t_raw  = 1'b0;
        mon.h_raw  = 1'b0;
        mon.ack    = 1'b0;
        #2;
        check("reset level",   {6'd0, mon.level},       8'd0);
        check("reset alarm",   {7'd0, mon.alarm},       8'd0);
        check("reset warning", {7'd0, mon.warning},     8'd0);
        check("reset t_clean", {7'd0, mon.t_clean},     8'd0);
        check("reset h_clean", {7'd0, mon.h_clean},     8'd0);
        check("reset tick",    {7'd0, mon.sample_tick}, 8'd0);
        check("reset events",  mon.alarm_events,        8'd0);

        @(posedge clock);
        @(posedge clock);
        #1;
        reset      = 1'b1;
        mon.enable = 1'b1;
        mon.t_raw  = 1'b1;

        // Tick on enabled cycles 4, 8, 12; t_clean after edge 12; WARN after edge 13.
        for (int k = 1; k <= 14; k++) begin
            step(1);
            check($sformatf("cadence tick k=%0d", k), {7'd0, mon.sample_tick},
                  ((k + 1) % 4 == 0) ? 8'd1 : 8'd0);
            check($sformatf("cadence t_clean k=%0d", k), {7'd0, mon.t_clean},
                  (k >= 12) ? 8'd1 : 8'd0);
            check($sformatf("cadence warning k=%0d", k), {7'd0, mon.warning},
                  (k >= 12) ? 8'd1 : 8'd0);
            check($sformatf("cadence level k=%0d", k), {6'd0, mon.level},
                  (k >= 13) ? 8'd2 : 8'd1);
        end

        mon.enable = 1'b0;
        step(1);
        check("warn disable level",   {6'd0, mon.level},   8'd0);
        check("warn disable t_clean", {7'd0, mon.t_clean}, 8'd0);
        check("warn disable h_clean", {7'd0, mon.h_clean}, 8'd0);
        check("warn disable warning", {7'd0, mon.warning}, 8'd0);

        for (int i = 0; i < 17; i++) begin
            mon.enable = tbl[i].en;
            mon.t_raw  = tbl[i].t;
            mon.h_raw  = tbl[i].h;
            mon.ack    = tbl[i].ack;
            step(tbl[i].n);
            check($sformatf("row%0d level", i),   {6'd0, mon.level},   {6'd0, tbl[i].lvl});
            check($sformatf("row%0d alarm", i),   {7'd0, mon.alarm},   {7'd0, tbl[i].alm});
            check($sformatf("row%0d t_clean", i), {7'd0, mon.t_clean}, {7'd0, tbl[i].tc});
            check($sformatf("row%0d h_clean", i), {7'd0, mon.h_clean}, {7'd0, tbl[i].hc});
            check($sformatf("row%0d warning", i), {7'd0, mon.warning}, {7'd0, tbl[i].wrn});
        end

        check("alarm events", mon.alarm_events, exp_events);

        // Asynchronous reset in the middle of an ALARM cycle, no clock edge in between.
        #3;
        reset = 1'b0;
        #1;
        check("async reset level",   {6'd0, mon.level},   8'd0);
        check("async reset alarm",   {7'd0, mon.alarm},   8'd0);
        check("async reset t_clean", {7'd0, mon.t_clean}, 8'd0);
        check("async reset warning", {7'd0, mon.warning}, 8'd0);
        check("async reset events",  mon.alarm_events,    8'd0);
        mon.t_raw  = 1'b0;
        mon.h_raw  = 1'b0;
        mon.enable = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("post reset level before edge", {6'd0, mon.level}, 8'd0);
        step(1);
        check("post reset level", {6'd0, mon.level}, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
